// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive control FSM, its edge/bit counter and sampler, and the system side.
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
);
    logic                      rx_in;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      par_typ;
    logic [PRESCALE_WIDTH-1:0] edge_count;
    logic [BIT_CNT_WIDTH-1:0]  bit_count;
    logic                      sampled_bit;
    logic                      counter_enable;
    logic                      data_samp_en;
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      parity_error;
    logic                      stop_error;
    logic                      break_det;

    modport master (
        input  rx_in, prescale, par_en, par_typ, edge_count, bit_count, sampled_bit,
        output counter_enable, data_samp_en, p_data, data_valid, parity_error, stop_error, break_det
    );

    modport slave (
        output rx_in, prescale, par_en, par_typ, edge_count, bit_count, sampled_bit,
        input  counter_enable, data_samp_en, p_data, data_valid, parity_error, stop_error, break_det
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: start detection, LSB-first deserialization, parity and stop checks.
// Optional break detection is built in when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fsm_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [2:0] BREAK  = 3'd5;
`endif

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  run_r;
    logic                  run_nxt_s;
    logic                  data_valid_r;
    logic                  parity_error_r;
    logic                  stop_error_r;
    logic                  break_det_r;
    logic                  end_of_bit_s;
    logic                  last_data_s;
    logic                  frame_ok_s;

    assign end_of_bit_s = run_r && (bus.edge_count == (bus.prescale - PRESCALE_WIDTH'(1)));
    assign last_data_s  = (bus.bit_count == BIT_CNT_WIDTH'(DATA_WIDTH));
    // parity_error_r already holds this frame's parity verdict when the stop bit is judged
    assign frame_ok_s   = bus.sampled_bit && !parity_error_r;

`ifdef UART_RX_BREAK_DETECT_EN
    logic par_bit_r;
    logic break_frame_s;
    assign break_frame_s = (shift_r == {DATA_WIDTH{1'b0}}) && !bus.sampled_bit
                           && (!bus.par_en || !par_bit_r);
`endif

    // Next-state decode for the frame sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!bus.rx_in) state_nxt_s = START;
                else            state_nxt_s = IDLE;
            end
            START: begin
                if (!end_of_bit_s)        state_nxt_s = START;
                else if (bus.sampled_bit) state_nxt_s = IDLE;
                else                      state_nxt_s = DATA;
            end
            DATA: begin
                if (!(end_of_bit_s && last_data_s)) state_nxt_s = DATA;
                else if (bus.par_en)                state_nxt_s = PARITY;
                else                                state_nxt_s = STOP;
            end
            PARITY: begin
                if (end_of_bit_s) state_nxt_s = STOP;
                else              state_nxt_s = PARITY;
            end
            STOP: begin
                if (!end_of_bit_s)       state_nxt_s = STOP;
`ifdef UART_RX_BREAK_DETECT_EN
                else if (break_frame_s) state_nxt_s = BREAK;
`endif
                else                     state_nxt_s = IDLE;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            BREAK: begin
                if (bus.rx_in) state_nxt_s = IDLE;
                else           state_nxt_s = BREAK;
            end
`endif
            default: state_nxt_s = IDLE;
        endcase
    end

    // Counter and sampler run in every active frame state
    always_comb begin
        run_nxt_s = 1'b1;
        if (state_nxt_s == IDLE)       run_nxt_s = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        else if (state_nxt_s == BREAK) run_nxt_s = 1'b0;
`endif
        else                           run_nxt_s = 1'b1;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            run_r          <= 1'b0;
            shift_r        <= {DATA_WIDTH{1'b0}};
            p_data_r       <= {DATA_WIDTH{1'b0}};
            data_valid_r   <= 1'b0;
            parity_error_r <= 1'b0;
            stop_error_r   <= 1'b0;
            break_det_r    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_r      <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            run_r        <= run_nxt_s;
            data_valid_r <= 1'b0;
            break_det_r  <= 1'b0;
            if ((state_r == IDLE) && !bus.rx_in) begin
                parity_error_r <= 1'b0;
                stop_error_r   <= 1'b0;
            end
            if ((state_r == DATA) && end_of_bit_s) begin
                shift_r <= {bus.sampled_bit, shift_r[DATA_WIDTH-1:1]};
            end
            if ((state_r == PARITY) && end_of_bit_s) begin
                parity_error_r <= bus.sampled_bit ^ (parity_of(shift_r) ^ bus.par_typ);
`ifdef UART_RX_BREAK_DETECT_EN
                par_bit_r      <= bus.sampled_bit;
`endif
            end
            if ((state_r == STOP) && end_of_bit_s) begin
                stop_error_r <= ~bus.sampled_bit;
                if (frame_ok_s) begin
                    p_data_r     <= shift_r;
                    data_valid_r <= 1'b1;
                end
`ifdef UART_RX_BREAK_DETECT_EN
                break_det_r <= break_frame_s;
`endif
            end
        end
    end

    assign bus.counter_enable = run_r;
    assign bus.data_samp_en   = run_r;
    assign bus.p_data         = p_data_r;
    assign bus.data_valid     = data_valid_r;
    assign bus.parity_error   = parity_error_r;
    assign bus.stop_error     = stop_error_r;
    assign bus.break_det      = break_det_r;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm with a behavioural edge/bit counter and mid-bit sampler.
module tb_uart_rx_fsm;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int BW = 4;
    localparam int PS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] ec;
    logic [BW-1:0] bc;
    logic          sb;
    int            n_checks = 0;
    int            n_fail = 0;
    int            dv_count = 0;
    int            brk_count = 0;
    logic [DW-1:0] last_good = 8'h00;
    logic [DW-1:0] exp_q [$];

    uart_rx_fsm_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.edge_count  = ec;
    assign bus.bit_count   = bc;
    assign bus.sampled_bit = sb;

    // Edge/bit counter and a sampler that captures rx_in in the middle of each bit
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ec <= 6'd0;
            bc <= 4'd0;
            sb <= 1'b1;
        end else if (!bus.counter_enable) begin
            ec <= 6'd0;
            bc <= 4'd0;
        end else begin
            if (ec == bus.prescale - 6'd1) begin
                ec <= 6'd0;
                bc <= bc + 4'd1;
            end else begin
                ec <= ec + 6'd1;
            end
            if (ec == (bus.prescale >> 1)) sb <= bus.rx_in;
        end
    end

    always @(posedge clk) begin
        if (bus.data_valid) dv_count <= dv_count + 1;
        if (bus.break_det)  brk_count <= brk_count + 1;
    end

    task automatic drive_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_in = bits[i];
            repeat (PS) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic use_par, input logic par_bit,
                              input logic stop_bit, input logic good, input logic hold_low,
                              input string name);
        logic [11:0]   b;
        logic [DW-1:0] exp;
        int            n;
        int            stop_idx;
        bit            found;
        if (use_par) begin
            b = {1'b0, stop_bit, par_bit, data, 1'b0};
            n = 11;
            stop_idx = DW + 2;
        end else begin
            b = {2'b00, stop_bit, data, 1'b0};
            n = 10;
            stop_idx = DW + 1;
        end
        if (good) exp_q.push_back(data);
        drive_bits(b, n - 1);
        n_checks++;
        if (bus.stop_error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_clears_stop_error: got %b expected 0", name, bus.stop_error);
        end
        bus.rx_in = b[n-1];
        found = 1'b0;
        for (int c = 0; c < 4 * PS && !found; c++) begin
            if (bus.counter_enable === 1'b1 && bc == stop_idx && ec == PS - 1) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s stop_timeout: stop end_of_bit not seen, expected within %0d cycles", name, 4 * PS);
        end
        @(negedge clk);
        if (!hold_low) bus.rx_in = 1'b1;
        n_checks++;
        if (bus.data_valid !== good) begin
            n_fail++;
            $display("FAIL %s data_valid: got %b expected %b", name, bus.data_valid, good);
        end
        n_checks++;
        if (good) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s scoreboard: got p_data %h with no expected word queued", name, bus.p_data);
            end else begin
                exp = exp_q.pop_front();
                if (bus.p_data !== exp) begin
                    n_fail++;
                    $display("FAIL %s p_data: got %h expected %h", name, bus.p_data, exp);
                end
                last_good = exp;
            end
        end else if (bus.p_data !== last_good) begin
            n_fail++;
            $display("FAIL %s p_data_hold: got %h expected %h", name, bus.p_data, last_good);
        end
        @(negedge clk);
        n_checks++;
        if (bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s data_valid_width: got %b expected 0", name, bus.data_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_in = 1'b1;
        bus.prescale = 6'd8;
        bus.par_en = 1'b0;
        bus.par_typ = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.counter_enable, bus.data_samp_en, bus.data_valid, bus.parity_error,
             bus.stop_error, bus.break_det} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {bus.counter_enable, bus.data_samp_en,
                     bus.data_valid, bus.parity_error, bus.stop_error, bus.break_det});
        end
        n_checks++;
        if (bus.p_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_p_data: got %h expected 00", bus.p_data);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.counter_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_counter_enable: got %b expected 0", bus.counter_enable);
        end
    endtask

    task automatic test_good_parity();
        bus.par_en = 1'b1;
        bus.par_typ = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "good_a5");
        n_checks++;
        if ({bus.parity_error, bus.stop_error} !== 2'b00) begin
            n_fail++;
            $display("FAIL good_a5 flags: got %b expected 00", {bus.parity_error, bus.stop_error});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        int  dv0;
        bit  dropped;
        dv0 = dv_count;
        bus.rx_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.counter_enable !== 1'b1 || bus.data_samp_en !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_start_enable: got %b%b expected 11", bus.counter_enable, bus.data_samp_en);
        end
        bus.rx_in = 1'b1;
        dropped = 1'b0;
        for (int c = 0; c < 3 * PS && !dropped; c++) begin
            @(negedge clk);
            if (bus.counter_enable === 1'b0) dropped = 1'b1;
        end
        n_checks++;
        if (!dropped) begin
            n_fail++;
            $display("FAIL glitch_return_idle: counter_enable still 1, expected 0 within %0d cycles", 3 * PS);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (dv_count != dv0 || bus.p_data !== last_good) begin
            n_fail++;
            $display("FAIL glitch_no_output: got valids %0d p_data %h expected 0 and %h",
                     dv_count - dv0, bus.p_data, last_good);
        end
    endtask

    task automatic test_parity_error();
        bus.par_en = 1'b1;
        bus.par_typ = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "odd_parity_bad");
        n_checks++;
        if ({bus.parity_error, bus.stop_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL odd_parity_bad flags: got %b expected 10", {bus.parity_error, bus.stop_error});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stop_error();
        bus.par_en = 1'b0;
        bus.par_typ = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stop_bad_3c");
        n_checks++;
        if ({bus.parity_error, bus.stop_error} !== 2'b01) begin
            n_fail++;
            $display("FAIL stop_bad_3c flags: got %b expected 01", {bus.parity_error, bus.stop_error});
        end
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "good_81");
        n_checks++;
        if ({bus.parity_error, bus.stop_error} !== 2'b00) begin
            n_fail++;
            $display("FAIL good_81 flags: got %b expected 00", {bus.parity_error, bus.stop_error});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        bus.par_en = 1'b0;
        drive_bits({2'b00, 1'b1, 8'h55, 1'b0}, 4);
        found = 1'b0;
        for (int c = 0; c < 2 * PS && !found; c++) begin
            if (bc == 4'd4) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reset_reach_bit4: bit_count %0d expected 4", bc);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.counter_enable, bus.data_samp_en, bus.data_valid, bus.parity_error,
             bus.stop_error, bus.break_det} !== 6'b000000 || bus.p_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got flags %b p_data %h expected 000000 and 00",
                     {bus.counter_enable, bus.data_samp_en, bus.data_valid, bus.parity_error,
                      bus.stop_error, bus.break_det}, bus.p_data);
        end
        last_good = 8'h00;
        @(negedge clk);
        bus.rx_in = 1'b1;
        rst = 1'b1;
        repeat (2 * PS) @(negedge clk);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "after_reset_55");
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.par_en = 1'b1;
        bus.par_typ = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b2b_12");
        send_frame(8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "b2b_34");
        repeat (4) @(negedge clk);
    endtask

    task automatic test_break();
        int brk0;
        int dv0;
        int ce_bad;
        bus.par_en = 1'b0;
        bus.par_typ = 1'b0;
        brk0 = brk_count;
        dv0 = dv_count;
`ifdef UART_RX_BREAK_DETECT_EN
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "break");
        ce_bad = 0;
        for (int i = 0; i < 2 * PS; i++) begin
            if (bus.counter_enable !== 1'b0) ce_bad++;
            @(negedge clk);
        end
        n_checks++;
        if (ce_bad != 0) begin
            n_fail++;
            $display("FAIL break_hold: counter_enable high %0d cycles while line low, expected 0", ce_bad);
        end
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (brk_count - brk0 != 1) begin
            n_fail++;
            $display("FAIL break_det_pulses: got %0d expected 1", brk_count - brk0);
        end
`else
        ce_bad = 0;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "break");
        n_checks++;
        if (brk_count != brk0 + ce_bad) begin
            n_fail++;
            $display("FAIL break_det_off: got %0d pulses expected 0", brk_count - brk0);
        end
`endif
        n_checks++;
        if (bus.stop_error !== 1'b1 || dv_count != dv0) begin
            n_fail++;
            $display("FAIL break_stop_error: got stop_error %b valids %0d expected 1 and 0",
                     bus.stop_error, dv_count - dv0);
        end
        repeat (4) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "after_break_5a");
    endtask

    initial begin
        test_reset();
        test_good_parity();
        test_glitch();
        test_parity_error();
        test_stop_error();
        test_reset_mid_frame();
        test_back_to_back();
        test_break();
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control stage of the UART receiver, sitting directly downstream of the edge/bit counter and the data sampler.
- Detects the start bit and enables the counter and sampler.
- Consumes edge_count, bit_count and sampled_bit, deserializes the data LSB first, and checks parity and stop bits.
- Presents the received word with a one-cycle valid strobe to the system side.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of prescale and edge_count.
- BIT_CNT_WIDTH, 4, width of bit_count; must hold DATA_WIDTH+2.

Ports:
- clk  input  1  receiver clock, oversampling rate (prescale × baud).
- rst  input  1  asynchronous, active-low reset.
- rx_in  input  1  raw serial line; idle high.
- prescale  input  PRESCALE_WIDTH  edges per bit; legal range 4..2^PRESCALE_WIDTH-1; must be stable while not IDLE.
- par_en  input  1  1 = a parity bit follows the data.
- par_typ  input  1  0 = even, 1 = odd.
- edge_count  input  PRESCALE_WIDTH  from the edge/bit counter; counts 0..prescale-1 within a bit.
- bit_count  input  BIT_CNT_WIDTH  from the edge/bit counter; 0 = start bit, 1..DATA_WIDTH = data, then parity, then stop.
- sampled_bit  input  1  majority-voted bit from the sampler; stable by edge_count == prescale-1.
- counter_enable  output  1  runs the edge/bit counter; low clears it.
- data_samp_en  output  1  enables the sampler.
- p_data  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle strobe when p_data updates.
- parity_error  output  1  sticky for the frame.
- stop_error  output  1  sticky for the frame.
- break_det  output  1  see Optional Feature.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE. counter_enable, data_samp_en, data_valid, parity_error, stop_error and break_det = 0. p_data = 0. Internal shift register = 0.
- end_of_bit is defined as (edge_count == prescale-1) while counter_enable = 1. All bit decisions are made on end_of_bit using sampled_bit.
- All outputs are registered.
- counter_enable = data_samp_en = 1 in every state except IDLE.
- IDLE:
  - data_valid = 0.
  - rx_in == 0 → START. Clear parity_error and stop_error on this transition.
  - The counter starts at edge 0 on the first START cycle.
- START, on end_of_bit:
  - sampled_bit == 1 (glitch) → IDLE. No flags change and data_valid is not asserted.
  - sampled_bit == 0 → DATA.
- DATA:
  - Each end_of_bit shifts sampled_bit into the shift register, LSB first (bit 1 lands in p_data[0]).
  - The end_of_bit with bit_count == DATA_WIDTH → PARITY if par_en, else STOP.
- PARITY, on end_of_bit:
  - parity_error <= sampled_bit XOR (^shift XOR par_typ).
  - → STOP.
- STOP, on end_of_bit:
  - stop_error <= ~sampled_bit.
  - If there is no parity or stop error in this frame: p_data <= shift and data_valid = 1 for exactly one cycle, the cycle after this end_of_bit.
  - → IDLE.
  - Counters are cleared by counter_enable = 0 for at least one cycle before the next start can be accepted.
- On a bad frame, p_data holds its previous value and the error flag stays high until the next START entry.
- prescale changing while not in IDLE produces undefined results; no checking is required.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at their reset values. The partial frame is discarded.
- rx_in held low continuously: a new frame starts after the one-cycle IDLE. Frames of all-zero data with stop = 0 report stop_error.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - A frame whose data is all zeros, whose parity bit (if enabled) is 0, and whose stop bit is 0 pulses break_det for one cycle, in the same cycle stop_error sets.
  - The FSM then enters a BREAK state: counter_enable = data_samp_en = 0, and it waits for rx_in == 1 before going to IDLE.
  - No new START is accepted while in BREAK.
- Undefined:
  - break_det is tied to 0 and the BREAK state does not exist.
  - Break frames are reported as ordinary stop errors and may immediately retrigger START.

Test Plan:
- prescale=8, par_en=1, par_typ=0, frame 0xA5 with parity 0 and stop 1 → data_valid for 1 cycle, one cycle after the stop end_of_bit; p_data=0xA5; both error flags 0.
- rx_in low for 3 cycles then high; sampled_bit=1 at the start end_of_bit → return to IDLE; counter_enable drops; no data_valid; p_data unchanged.
- par_typ=1, frame 0xA5 with parity bit 0 → parity_error=1; no data_valid; p_data keeps 0xA5 from the prior frame.
- par_en=0, frame 0x3C with stop bit 0 → stop_error=1, no data_valid. The next good frame 0x81 clears stop_error at START and produces p_data=0x81.
- rst pulled low at bit_count=4 of a frame → all outputs reset asynchronously. A following clean frame 0x55 is received correctly.
- With UART_RX_BREAK_DETECT_EN defined: rx_in held low for 12 bit times → break_det pulses once; FSM stays in BREAK until rx_in=1, then IDLE; no data_valid.
